// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and hands {instr, pc} to decode over valid/ready. Redirects override everything.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        kill_q, kill_d;
  logic        run_q;
  logic        req_fire;
  logic [31:0] redir_pc;

  // run_q keeps the request low for the whole reset window and releases it one
  // edge later, so nothing reaches imem from an asynchronously reset state.
  assign imem_req_valid = run_q && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redir_pc       = {redirect_pc[31:1], 1'b0};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      S_REQ: if (req_fire) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          if (!kill_q) begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'(PC_STEP);
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over the normal flow; an in-flight request becomes a kill.
    if (redirect_valid) begin
      pc_d = redir_pc;
      unique case (state_q)
        S_REQ:  kill_d = req_fire;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d    = S_REQ;
            kill_d     = 1'b0;
            if_valid_d = 1'b0;
            if_instr_d = if_instr_q;
            if_pc_d    = if_pc_q;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: random imem/decode/redirect traffic against a
// "next delivered PC" reference model, plus directed reset, backpressure and redirect cases.
module tb_fetch_pc_unit;
  localparam logic [31:0] RPC = 32'hFFFF_FFF4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;

  fetch_pc_unit #(.RESET_PC(RPC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } item_t;

  item_t       exp_q[$];
  item_t       mon_e;
  int          n_cmp = 0, n_err = 0, n_deliv = 0, cyc = 0, last_hs = -1;
  logic        seq_mode = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_a = 32'h0, cur_pc = 32'h0;
  int          lat = 0;
  logic        p_hold = 1'b0, p_hs = 1'b0, p_red = 1'b0;
  logic [31:0] p_pc = 32'h0, p_in = 32'h0, p_rpc = 32'h0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  function automatic item_t mk(input logic [31:0] a);
    item_t it;
    it.pc    = a;
    it.instr = mem_f(a);
    return it;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples at negedge, pops the scoreboard on every decode handshake.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        p_hold = 1'b0; p_hs = 1'b0; p_red = 1'b0; last_hs = -1;
      end else begin
        chk("req_during_hold", {31'b0, imem_req_valid & if_valid}, 32'd0);
        if (p_hold) begin
          chk("hold_valid", {31'b0, if_valid}, 32'd1);
          chk("hold_pc", if_pc, p_pc);
          chk("hold_instr", if_instr, p_in);
        end
        if (p_hs) begin
          chk("next_req_valid", {31'b0, imem_req_valid}, 32'd1);
          chk("next_req_addr", imem_addr, p_pc + 32'd4);
        end
        if (p_red) begin
          chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
          chk("redir_addr", imem_addr, p_rpc);
        end
        if (if_valid && if_ready) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_underflow: got delivery pc %h expected none", if_pc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("if_pc", if_pc, mon_e.pc);
            chk("if_instr", if_instr, mon_e.instr);
          end
          if (seq_mode) begin
            if (last_hs >= 0) chk("cadence", cyc - last_hs, 32'd3);
            last_hs = cyc;
          end
        end
        if (!seq_mode) last_hs = -1;
        p_hold = if_valid && !if_ready && !redirect_valid;
        p_hs   = if_valid && if_ready && !redirect_valid;
        p_red  = redirect_valid;
        p_pc   = if_pc;
        p_in   = if_instr;
        p_rpc  = redirect_pc & ~32'h1;
      end
    end
  end

  task automatic reset_model();
    pend   = 1'b0;
    cur_pc = RPC;
    exp_q.delete();
    exp_q.push_back(mk(RPC));
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
  endtask

  // One cycle of stimulus: imem responder, decode readiness, redirects, and the
  // reference model (next delivered pc = redirect target, else previous + 4).
  task automatic step(input int p_red_pct, input int p_ifr, input int p_mr, input int max_lat,
                      input logic frc = 1'b0, input logic [31:0] fpc = 32'h0);
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend) begin
      chk("one_outstanding", {31'b0, imem_req_valid}, 32'd0);
      if (lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_f(pend_a);
        pend = 1'b0;
      end else lat--;
    end
    imem_req_ready = ($urandom_range(99) < p_mr);
    if_ready       = ($urandom_range(99) < p_ifr);
    redirect_valid = frc || ($urandom_range(99) < p_red_pct);
    if (frc) redirect_pc = fpc;
    else     redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                    : $urandom_range(1023);
    if (imem_req_valid && imem_req_ready) begin
      pend   = 1'b1;
      pend_a = imem_addr;
      lat    = $urandom_range(max_lat);
    end
    if ((if_valid && if_ready) || redirect_valid) begin
      if (!(if_valid && if_ready) && exp_q.size() != 0) void'(exp_q.pop_back());
      cur_pc = redirect_valid ? (redirect_pc & ~32'h1) : cur_pc + 32'd4;
      exp_q.push_back(mk(cur_pc));
    end
  endtask

  initial begin
    int k;
    reset_model();
    repeat (2) @(posedge clk);
    #1 chk_reset_outs();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, RPC);

    // Back-to-back sequential fetch across the 32-bit wrap.
    seq_mode = 1'b1;
    repeat (20) step(0, 100, 100, 0);
    seq_mode = 1'b0;

    // Decode backpressure: hold the instruction for several cycles.
    k = 0;
    while (!if_valid && k < 20) begin step(0, 0, 100, 1); k++; end
    chk("bp_reached_hold", {31'b0, if_valid}, 32'd1);
    repeat (5) step(0, 0, 100, 1);
    repeat (6) step(0, 100, 100, 1);

    // Redirect while waiting on imem, before the response.
    k = 0;
    while (!(pend && lat > 0) && k < 40) begin step(0, 100, 100, 3); k++; end
    chk("wait_reached", {31'b0, pend && lat > 0}, 32'd1);
    step(0, 100, 0, 3, 1'b1, 32'h100);
    repeat (10) step(0, 100, 100, 2);

    // Redirect to an odd address while decode stalls.
    k = 0;
    while (!if_valid && k < 20) begin step(0, 0, 100, 1); k++; end
    chk("hold_reached", {31'b0, if_valid}, 32'd1);
    step(0, 0, 100, 1, 1'b1, 32'h41);
    repeat (10) step(0, 100, 100, 1);

    repeat (500) step(10, 60, 70, 3);

    // Reset pulse mid-WAIT, with a stale response arriving afterwards.
    k = 0;
    while (!(pend && lat > 0) && k < 40) begin step(0, 100, 100, 3); k++; end
    chk("wait_before_rst", {31'b0, pend && lat > 0}, 32'd1);
    @(posedge clk); #1;
    imem_req_ready = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outs();
    @(posedge clk); #1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rearm_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rearm_addr", imem_addr, RPC);
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    chk("stale_rsp_ignored", {31'b0, if_valid}, 32'd0);
    chk("stale_still_req", {31'b0, imem_req_valid}, 32'd1);
    reset_model();

    repeat (300) step(10, 60, 70, 3);
    repeat (10) step(0, 100, 100, 0);

    chk("deliveries_seen", {31'b0, n_deliv >= 60}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
